dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Responder (memory side) for the pipeline's data-memory request channel: the counterpart to the MEM stage's load/store initiator.
- Accepts one load/store request at a time through a valid/ready handshake. Performs the RISC-V sub-word access (LB/LH/LW/LBU/LHU/SB/SH/SW) against a byte-enabled synchronous RAM.
- Returns an aligned, extended read result plus error flags.
- A thin wrapper binds these flat ports to the provider side of inner_memory_if.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; word index = req_addr[31:2].
- INIT_FILE, "", hex file loaded at elaboration; empty means contents undefined.
- MMIO_ADDR, 32'hFFFF_FFF0, word address of the tohost register (used only with the optional feature).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request this cycle
- req_write  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- req_funct3  in  3  RISC-V funct3 of the load/store
- resp_valid  out  1  one-cycle pulse: response available
- resp_rdata  out  32  load result, sign/zero-extended; 0 for stores and errors
- resp_err  out  2  bit0 = misaligned; bit1 = out-of-range or illegal funct3
- tohost_data  out  32  last value stored to MMIO_ADDR
- tohost_valid  out  1  one-cycle pulse on an MMIO store

Behaviour:
- Reset state: state = IDLE; req_ready = 1; resp_valid = 0; resp_rdata = 0; resp_err = 0; tohost_data = 0; tohost_valid = 0. RAM contents are not reset.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready = 1.
  - Handshake (req_valid & req_ready) latches write, addr, wdata, funct3 and goes to ACCESS.
- ACCESS:
  - req_ready = 0.
  - Error check on the latched request. Misaligned: halfword with addr[0] = 1, or word with addr[1:0] != 0. Range error: word index >= DEPTH_WORDS, load funct3 in {3,6,7}, or store funct3 >= 3.
  - Store with no error: RAM write at this clock edge.
    - Byte enables: SB = 4'b0001 << addr[1:0]; SH = 4'b0011 << addr[1:0]; SW = 4'b1111.
    - wdata is replicated into the lanes.
  - Load: RAM read registered at this edge.
  - Next state: RESP.
- RESP:
  - resp_valid = 1 for exactly one cycle.
  - Load result: rdata is the selected byte/halfword shifted down. LB/LH sign-extend; LBU/LHU zero-extend.
  - Any error: no write has occurred, resp_rdata = 0, resp_err set.
  - req_ready = 1. A handshake here goes directly to ACCESS; otherwise the FSM goes to IDLE.
- Timing: latency from handshake to resp_valid is 2 cycles; sustained throughput is 1 request per 2 cycles.
- Outputs: resp_rdata and resp_err are valid only while resp_valid = 1 and are held at the last value otherwise.
- Boundaries:
  - Address 0 and word DEPTH_WORDS-1 are legal; there is no wrap-around.
  - Both error bits may be set together.
  - Inputs are ignored while req_ready = 0.
- Reset mid-operation:
  - Reset in ACCESS before the clock edge: the store is not committed and no response is issued.
  - Reset in RESP: the pending response is dropped; the store is already committed.

Optional Feature:
- Macro: DMEM_RESPONDER_MMIO_EN.
- Defined:
  - A store of any width to MMIO_ADDR (word-compared on addr[31:2]) writes the merged bytes into tohost_data.
  - tohost_valid pulses in the RESP cycle.
  - The RAM is untouched and there is no range error.
  - A load from MMIO_ADDR returns tohost_data, extended per funct3.
- Undefined:
  - tohost_data = 0 and tohost_valid = 0 permanently.
  - MMIO_ADDR is an ordinary address and is normally out of range.

Decomposition:
- Package dmem_pkg holds:
  - funct3 constants: LB=0, LH=1, LW=2, LBU=4, LHU=5, SB=0, SH=1, SW=2.
  - state enum dmem_state_t.
  - error bit indices ERR_MISALIGN=0, ERR_RANGE=1.
- Sub-module dmem_lane_align (combinational):
  - Store path: byte enables and lane-replicated wdata.
  - Load path: shift/extend.
  - Error decode.
- The RAM array is inferred inside dmem_responder.

Test Plan:
- SW 0xDEADBEEF to 0x100, then LW 0x100 -> resp_valid exactly 2 cycles after each handshake; resp_rdata = 0xDEADBEEF; resp_err = 0.
- After the above: SB 0x7F to 0x101, then LB 0x101 = 0x0000007F; LW 0x100 = 0xDEAD7FEF. Then SH 0x8001 to 0x102, and LH 0x102 = 0xFFFF8001, LHU 0x102 = 0x00008001.
- LW at 0x102, and SH at 0x103 -> resp_err = 2'b01, resp_rdata = 0; a following LW 0x100 shows memory unchanged.
- LW at byte address 4*DEPTH_WORDS (0x1000) -> resp_err = 2'b10. Load funct3 = 3 at 0x0 -> resp_err = 2'b10.
- Back-to-back: req_valid held high for 4 requests -> handshakes every 2 cycles, responses every 2 cycles, in order.
- Assert reset during ACCESS of SW 0x12345678 to 0x200 -> no resp_valid; req_ready = 1 after reset; LW 0x200 returns the old value. With DMEM_RESPONDER_MMIO_EN: SW 0x41 to 0xFFFFFFF0 -> tohost_valid pulse, tohost_data = 0x41.

Source files
------------

// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder: RISC-V load/store funct3
// codes, the responder FSM state type, error-bit positions and a byte-merge
// helper used when a store updates only some lanes of a 32-bit word.
// No ports (package).
// ---------------------------------------------------------------------------
package dmem_pkg;

   // Load funct3 codes
   localparam logic [2:0] LB  = 3'd0;
   localparam logic [2:0] LH  = 3'd1;
   localparam logic [2:0] LW  = 3'd2;
   localparam logic [2:0] LBU = 3'd4;
   localparam logic [2:0] LHU = 3'd5;

   // Store funct3 codes
   localparam logic [2:0] SB  = 3'd0;
   localparam logic [2:0] SH  = 3'd1;
   localparam logic [2:0] SW  = 3'd2;

   // Bit positions inside resp_err
   localparam int ERR_MISALIGN = 0;
   localparam int ERR_RANGE    = 1;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } dmem_state_t;

   // Replace the bytes of old_word whose enable bit is set with the matching
   // bytes of new_word.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  byte_en);
      logic [31:0] merged;
      merged = old_word;
      for (int b = 0; b < 4; b++) begin
         if (byte_en[b]) begin
            merged[8*b +: 8] = new_word[8*b +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// ---------------------------------------------------------------------------
// dmem_lane_align
// Purely combinational lane logic for the data-memory responder.
//   - Error decode: misalignment and out-of-range / illegal funct3.
//   - Store path: byte enables and wdata replicated into every lane.
//   - Load path: selected byte/halfword shifted down and sign/zero extended.
// Ports:
//   write     in   1  latched request is a store
//   addr      in  32  latched byte address
//   wdata     in  32  latched store data, right-justified
//   funct3    in   3  latched RISC-V funct3
//   mmio_hit  in   1  address hits the tohost register (exempt from range)
//   rword     in  32  raw 32-bit word read from RAM or tohost
//   byte_en   out  4  store byte enables, zero for loads and errors
//   wlanes    out 32  store data replicated across lanes
//   rdata     out 32  extended load result, zero for stores and errors
//   err       out  2  bit0 misaligned, bit1 range / illegal funct3
// ---------------------------------------------------------------------------
module dmem_lane_align
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic        write,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [2:0]  funct3,
   input  logic        mmio_hit,
   input  logic [31:0] rword,
   output logic [3:0]  byte_en,
   output logic [31:0] wlanes,
   output logic [31:0] rdata,
   output logic [1:0]  err
);

   logic        legal;
   logic        is_half;
   logic        is_word;
   logic        misalign;
   logic        out_of_range;
   logic [31:0] shifted;

   // Error decode. Size-based misalignment only applies to legal encodings;
   // an illegal funct3 is reported purely as a range error. LHU (5) is a
   // halfword only for loads, since store funct3 5 is illegal.
   always_comb begin
      if (write) begin
         legal = (funct3 == SB) || (funct3 == SH) || (funct3 == SW);
      end else begin
         legal = (funct3 == LB) || (funct3 == LH) || (funct3 == LW) ||
                 (funct3 == LBU) || (funct3 == LHU);
      end
      is_half      = (funct3 == LH) || (!write && (funct3 == LHU));
      is_word      = (funct3 == LW);
      misalign     = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
      out_of_range = !mmio_hit && ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS));
      err               = '0;
      err[ERR_MISALIGN] = misalign;
      err[ERR_RANGE]    = !legal || out_of_range;
   end

   // Store path: replicate the right-justified data into every lane so the
   // byte enables alone select where it lands.
   always_comb begin
      case (funct3)
         SB:      wlanes = {4{wdata[7:0]}};
         SH:      wlanes = {2{wdata[15:0]}};
         default: wlanes = wdata;
      endcase
      byte_en = 4'b0000;
      if (write && (err == 2'b00)) begin
         case (funct3)
            SB:      byte_en = 4'b0001 << addr[1:0];
            SH:      byte_en = 4'b0011 << addr[1:0];
            SW:      byte_en = 4'b1111;
            default: byte_en = 4'b0000;
         endcase
      end
   end

   // Load path: shift the addressed lane down to bit 0, then extend.
   always_comb begin
      shifted = rword >> {addr[1:0], 3'b000};
      case (funct3)
         LB:      rdata = {{24{shifted[7]}}, shifted[7:0]};
         LH:      rdata = {{16{shifted[15]}}, shifted[15:0]};
         LW:      rdata = rword;
         LBU:     rdata = {24'h000000, shifted[7:0]};
         LHU:     rdata = {16'h0000, shifted[15:0]};
         default: rdata = '0;
      endcase
      if (write || (err != 2'b00)) begin
         rdata = '0;
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Memory-side responder for the pipeline's data-memory request channel.
// Accepts one load/store at a time over valid/ready, performs the RISC-V
// sub-word access against an inferred byte-enabled RAM and returns an
// aligned, extended result with error flags two cycles after the handshake.
//
// Optional feature (macro DMEM_RESPONDER_MMIO_EN): stores to MMIO_ADDR update
// the tohost register and pulse tohost_valid; loads from it return tohost.
// Without the macro, tohost outputs are constant zero and MMIO_ADDR is an
// ordinary (normally out-of-range) address.
//
// Ports:
//   clk           in   1  clock
//   reset         in   1  asynchronous, active-high reset
//   req_valid     in   1  request present
//   req_ready     out  1  responder can accept a request this cycle
//   req_write     in   1  1 = store, 0 = load
//   req_addr      in  32  byte address
//   req_wdata     in  32  store data, right-justified
//   req_funct3    in   3  RISC-V funct3 of the load/store
//   resp_valid    out  1  one-cycle response pulse
//   resp_rdata    out 32  load result; 0 for stores and errors
//   resp_err      out  2  bit0 misaligned, bit1 range / illegal funct3
//   tohost_data   out 32  last value stored to MMIO_ADDR
//   tohost_valid  out  1  one-cycle pulse on an MMIO store
// ---------------------------------------------------------------------------
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter string       INIT_FILE   = "",
   parameter logic [31:0] MMIO_ADDR   = 32'hFFFF_FFF0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_funct3,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic [1:0]  resp_err,
   output logic [31:0] tohost_data,
   output logic        tohost_valid
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

`ifdef DMEM_RESPONDER_MMIO_EN
   localparam bit MMIO_EN = 1'b1;
`else
   localparam bit MMIO_EN = 1'b0;
`endif

   dmem_state_t      state;
   logic             lat_write;
   logic [31:0]      lat_addr;
   logic [31:0]      lat_wdata;
   logic [2:0]       lat_funct3;

   logic             accept;
   logic             mmio_hit;
   logic [IDX_W-1:0] idx;
   logic [31:0]      rword;
   logic [3:0]       byte_en;
   logic [31:0]      wlanes;
   logic [31:0]      rdata;
   logic [1:0]       err;
   logic             ram_we;

   logic [31:0]      mem [DEPTH_WORDS];

   assign accept   = req_valid && req_ready;
   assign idx      = lat_addr[IDX_W+1:2];
   assign mmio_hit = MMIO_EN && (lat_addr[31:2] == MMIO_ADDR[31:2]);
   assign ram_we   = (state == ACCESS) && lat_write && !mmio_hit;

   dmem_lane_align #(
      .DEPTH_WORDS(DEPTH_WORDS)
   ) u_lane_align (
      .write   (lat_write),
      .addr    (lat_addr),
      .wdata   (lat_wdata),
      .funct3  (lat_funct3),
      .mmio_hit(mmio_hit),
      .rword   (rword),
      .byte_en (byte_en),
      .wlanes  (wlanes),
      .rdata   (rdata),
      .err     (err)
   );

   // Request holding registers. req_ready is only high in IDLE and RESP, so
   // anything presented while a request is in ACCESS is simply ignored.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lat_write  <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         lat_funct3 <= '0;
      end else if (accept) begin
         lat_write  <= req_write;
         lat_addr   <= req_addr;
         lat_wdata  <= req_wdata;
         lat_funct3 <= req_funct3;
      end
   end

   // Byte-enabled RAM write during ACCESS. byte_en is already zero on any
   // error, and because ram_we depends on the reset-cleared state, a reset
   // asserted during ACCESS prevents the commit.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) begin
               mem[idx][8*b +: 8] <= wlanes[8*b +: 8];
            end
         end
      end
   end

`ifdef DMEM_RESPONDER_MMIO_EN
   // tohost register: merged store bytes land here instead of the RAM, and
   // the pulse lines up with the RESP cycle of that store.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tohost_data  <= '0;
         tohost_valid <= 1'b0;
      end else begin
         tohost_valid <= 1'b0;
         if ((state == ACCESS) && lat_write && mmio_hit && (err == 2'b00)) begin
            tohost_data  <= merge_bytes(tohost_data, wlanes, byte_en);
            tohost_valid <= 1'b1;
         end
      end
   end

   assign rword = mmio_hit ? tohost_data : mem[idx];
`else
   assign tohost_data  = '0;
   assign tohost_valid = 1'b0;
   assign rword        = mem[idx];
`endif

   // Main FSM. The read and the extension are both captured at the ACCESS
   // edge, so resp_rdata/resp_err appear with resp_valid and then hold until
   // the next ACCESS edge regardless of what is latched meanwhile.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= '0;
      end else begin
         case (state)
            IDLE: begin
               resp_valid <= 1'b0;
               if (accept) begin
                  state     <= ACCESS;
                  req_ready <= 1'b0;
               end
            end
            ACCESS: begin
               resp_rdata <= rdata;
               resp_err   <= err;
               resp_valid <= 1'b1;
               req_ready  <= 1'b1;
               state      <= RESP;
            end
            RESP: begin
               resp_valid <= 1'b0;
               if (accept) begin
                  state     <= ACCESS;
                  req_ready <= 1'b0;
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               state      <= IDLE;
               req_ready  <= 1'b1;
               resp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
// Self-checking bench for dmem_responder: a table of directed vectors, hand
// sequences for back-to-back traffic and mid-operation reset, and random
// traffic compared against a byte-level memory model.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

   localparam int          DEPTH     = 1024;
   localparam logic [31:0] MMIO_ADDR = 32'hFFFF_FFF0;

`ifdef DMEM_RESPONDER_MMIO_EN
   localparam bit MMIO_EN = 1'b1;
`else
   localparam bit MMIO_EN = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_funct3;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic [1:0]  resp_err;
   logic [31:0] tohost_data;
   logic        tohost_valid;

   int checks   = 0;
   int failures = 0;
   int tohost_pulses     = 0;
   int exp_tohost_pulses = 0;

   logic [31:0] model_mem [DEPTH];
   logic [31:0] model_tohost = '0;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  f3;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_err;
      string       name;
   } vec_t;

   vec_t vecs[$];

   dmem_responder #(
      .DEPTH_WORDS(DEPTH),
      .INIT_FILE  (""),
      .MMIO_ADDR  (MMIO_ADDR)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_funct3  (req_funct3),
      .resp_valid  (resp_valid),
      .resp_rdata  (resp_rdata),
      .resp_err    (resp_err),
      .tohost_data (tohost_data),
      .tohost_valid(tohost_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count every tohost pulse seen mid-cycle.
   always @(negedge clk) begin
      if (tohost_valid === 1'b1) tohost_pulses++;
   end

   // Hard stop in case the bench itself gets stuck.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic bit is_mmio(input logic [31:0] addr);
      return MMIO_EN && (addr[31:2] == MMIO_ADDR[31:2]);
   endfunction

   // Reference model: access size from funct3, misalignment as addr mod size,
   // bytes moved one at a time into/out of a word array.
   function automatic void model_access(input bit wr, input logic [31:0] addr,
                                        input logic [31:0] wdata, input logic [2:0] f3,
                                        output logic [31:0] rdata, output logic [1:0] err);
      int          size;
      bit          legal;
      bit          sgn;
      int          off;
      int          w;
      logic [31:0] word;
      logic [31:0] val;
      legal = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      case (f3)
         3'd0, 3'd4: size = 1;
         3'd1, 3'd5: size = 2;
         3'd2:       size = 4;
         default:    size = 1;
      endcase
      sgn = (f3 == 3'd0) || (f3 == 3'd1);
      off = int'(addr % 4);
      w   = int'(addr / 4);
      err = 2'b00;
      err[0] = legal && ((addr % size) != 0);
      err[1] = !legal || (!is_mmio(addr) && ((addr / 4) >= DEPTH));
      rdata = '0;
      if (err != 2'b00) return;
      if (wr) begin
         for (int b = 0; b < size; b++) begin
            if (is_mmio(addr)) model_tohost[8*(off+b) +: 8] = wdata[8*b +: 8];
            else               model_mem[w][8*(off+b) +: 8] = wdata[8*b +: 8];
         end
      end else begin
         word = is_mmio(addr) ? model_tohost : model_mem[w];
         val  = '0;
         for (int b = 0; b < size; b++) val[8*b +: 8] = word[8*(off+b) +: 8];
         if (sgn && size == 1) val = {{24{val[7]}}, val[7:0]};
         if (sgn && size == 2) val = {{16{val[15]}}, val[15:0]};
         rdata = val;
      end
   endfunction

   task automatic drive(input bit wr, input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] f3);
      req_write  = wr;
      req_addr   = addr;
      req_wdata  = wdata;
      req_funct3 = f3;
   endtask

   // One request from a negedge with req_ready expected high; returns at the
   // negedge of the response cycle. Table expectations override the model.
   task automatic apply_stimulus(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [2:0] f3, input string name,
                                 input bit has_table, input logic [31:0] tab_rdata,
                                 input logic [1:0] tab_err);
      logic [31:0] exp_rdata;
      logic [1:0]  exp_err;
      bit          exp_tohost;
      int          cycles;
      model_access(wr, addr, wdata, f3, exp_rdata, exp_err);
      exp_tohost = wr && (exp_err == 2'b00) && is_mmio(addr);
      if (has_table) begin
         exp_rdata = tab_rdata;
         exp_err   = tab_err;
      end
      cycles = 0;
      while (req_ready !== 1'b1 && cycles < 8) begin
         @(negedge clk);
         cycles++;
      end
      check_output({name, ":ready"}, 32'(req_ready), 32'd1);
      drive(wr, addr, wdata, f3);
      req_valid = 1'b1;
      @(posedge clk);
      cycles = 0;
      while (cycles < 8) begin
         @(negedge clk);
         cycles++;
         if (cycles == 1) begin
            req_valid = 1'b0;
            check_output({name, ":busy"}, 32'(req_ready), 32'd0);
         end
         if (resp_valid === 1'b1) break;
      end
      check_output({name, ":latency"}, 32'(cycles), 32'd2);
      if (resp_valid === 1'b1) begin
         check_output({name, ":rdata"}, resp_rdata, exp_rdata);
         check_output({name, ":err"}, 32'(resp_err), 32'(exp_err));
         check_output({name, ":tohost_valid"}, 32'(tohost_valid), 32'(exp_tohost));
         check_output({name, ":tohost_data"}, tohost_data, model_tohost);
         if (exp_tohost) exp_tohost_pulses++;
      end
   endtask

   task automatic check_reset_state(input string name);
      check_output({name, ":req_ready"}, 32'(req_ready), 32'd1);
      check_output({name, ":resp_valid"}, 32'(resp_valid), 32'd0);
      check_output({name, ":resp_rdata"}, resp_rdata, 32'd0);
      check_output({name, ":resp_err"}, 32'(resp_err), 32'd0);
      check_output({name, ":tohost_data"}, tohost_data, 32'd0);
      check_output({name, ":tohost_valid"}, 32'(tohost_valid), 32'd0);
   endtask

   function automatic vec_t mk(input bit wr, input logic [31:0] a, input logic [31:0] d,
                               input logic [2:0] f, input logic [31:0] r,
                               input logic [1:0] e, input string n);
      vec_t v;
      v.wr = wr; v.addr = a; v.wdata = d; v.f3 = f;
      v.exp_rdata = r; v.exp_err = e; v.name = n;
      return v;
   endfunction

   initial begin
      bit          b2b_wr [4];
      logic [31:0] b2b_addr [4];
      logic [31:0] b2b_wd [4];
      logic [2:0]  b2b_f3 [4];
      logic [31:0] b2b_rd [4];
      logic [1:0]  b2b_err [4];
      logic [29:0] word;
      logic [31:0] addr;
      logic [2:0]  f3;
      bit          wr;
      int          r;
      logic [2:0]  ld_codes [5];
      ld_codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

      reset = 1'b1;
      req_valid = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 3'd0);
      repeat (3) @(negedge clk);
      check_reset_state("reset");
      reset = 1'b0;
      @(negedge clk);

      // Directed vectors.
      vecs.push_back(mk(1, 32'h100, 32'hDEADBEEF, 3'd2, 32'h0, 2'b00, "sw_100"));
      vecs.push_back(mk(0, 32'h100, 32'h0, 3'd2, 32'hDEADBEEF, 2'b00, "lw_100"));
      vecs.push_back(mk(1, 32'h101, 32'h0000007F, 3'd0, 32'h0, 2'b00, "sb_101"));
      vecs.push_back(mk(0, 32'h101, 32'h0, 3'd0, 32'h0000007F, 2'b00, "lb_101"));
      vecs.push_back(mk(0, 32'h100, 32'h0, 3'd2, 32'hDEAD7FEF, 2'b00, "lw_100_b"));
      vecs.push_back(mk(1, 32'h102, 32'h00008001, 3'd1, 32'h0, 2'b00, "sh_102"));
      vecs.push_back(mk(0, 32'h102, 32'h0, 3'd1, 32'hFFFF8001, 2'b00, "lh_102"));
      vecs.push_back(mk(0, 32'h102, 32'h0, 3'd5, 32'h00008001, 2'b00, "lhu_102"));
      vecs.push_back(mk(0, 32'h102, 32'h0, 3'd2, 32'h0, 2'b01, "lw_misalign"));
      vecs.push_back(mk(1, 32'h103, 32'h00001234, 3'd1, 32'h0, 2'b01, "sh_misalign"));
      vecs.push_back(mk(0, 32'h100, 32'h0, 3'd2, 32'h80017FEF, 2'b00, "lw_unchanged"));
      vecs.push_back(mk(0, 32'h103, 32'h0, 3'd0, 32'hFFFFFF80, 2'b00, "lb_103"));
      vecs.push_back(mk(0, 32'h103, 32'h0, 3'd4, 32'h00000080, 2'b00, "lbu_103"));
      vecs.push_back(mk(0, 32'h100, 32'h0, 3'd1, 32'h00007FEF, 2'b00, "lh_100"));
      vecs.push_back(mk(0, 32'h1000, 32'h0, 3'd2, 32'h0, 2'b10, "lw_range"));
      vecs.push_back(mk(0, 32'h0, 32'h0, 3'd3, 32'h0, 2'b10, "ld_f3_3"));
      vecs.push_back(mk(1, 32'h0, 32'h55, 3'd3, 32'h0, 2'b10, "st_f3_3"));
      vecs.push_back(mk(0, 32'h1002, 32'h0, 3'd2, 32'h0, 2'b11, "lw_both_err"));
      vecs.push_back(mk(1, 32'h0, 32'h11223344, 3'd2, 32'h0, 2'b00, "sw_0"));
      vecs.push_back(mk(0, 32'h2, 32'h0, 3'd5, 32'h00001122, 2'b00, "lhu_2"));
      vecs.push_back(mk(0, 32'h0, 32'h0, 3'd2, 32'h11223344, 2'b00, "lw_0"));
      vecs.push_back(mk(1, 32'hFFC, 32'hA5A55A5A, 3'd2, 32'h0, 2'b00, "sw_last"));
      vecs.push_back(mk(0, 32'hFFE, 32'h0, 3'd1, 32'hFFFFA5A5, 2'b00, "lh_last"));
      vecs.push_back(mk(0, 32'hFFC, 32'h0, 3'd2, 32'hA5A55A5A, 2'b00, "lw_last"));
      vecs.push_back(mk(1, MMIO_ADDR, 32'h41, 3'd2, 32'h0, MMIO_EN ? 2'b00 : 2'b10, "sw_mmio"));
      vecs.push_back(mk(0, MMIO_ADDR, 32'h0, 3'd2, MMIO_EN ? 32'h41 : 32'h0,
                        MMIO_EN ? 2'b00 : 2'b10, "lw_mmio"));
      vecs.push_back(mk(1, MMIO_ADDR + 1, 32'h99, 3'd0, 32'h0, MMIO_EN ? 2'b00 : 2'b10, "sb_mmio"));
      vecs.push_back(mk(0, MMIO_ADDR + 1, 32'h0, 3'd4, MMIO_EN ? 32'h99 : 32'h0,
                        MMIO_EN ? 2'b00 : 2'b10, "lbu_mmio"));
      vecs.push_back(mk(1, 32'h200, 32'hCAFEF00D, 3'd2, 32'h0, 2'b00, "sw_200"));
      for (int i = 0; i < vecs.size(); i++) begin
         apply_stimulus(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].f3, vecs[i].name,
                        1'b1, vecs[i].exp_rdata, vecs[i].exp_err);
      end
      @(negedge clk);

      // Back-to-back: req_valid held high; junk presented during ACCESS must
      // be ignored.
      b2b_wr   = '{1'b1, 1'b0, 1'b0, 1'b0};
      b2b_addr = '{32'h8, 32'h8, 32'h9, 32'h100};
      b2b_wd   = '{32'h00005555, 32'h0, 32'h0, 32'h0};
      b2b_f3   = '{3'd2, 3'd2, 3'd4, 3'd2};
      for (int k = 0; k < 4; k++) begin
         model_access(b2b_wr[k], b2b_addr[k], b2b_wd[k], b2b_f3[k], b2b_rd[k], b2b_err[k]);
      end
      drive(b2b_wr[0], b2b_addr[0], b2b_wd[0], b2b_f3[0]);
      req_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check_output("b2b:ready", 32'(req_ready), 32'd1);
         @(posedge clk);
         @(negedge clk);
         check_output("b2b:access_valid", 32'(resp_valid), 32'd0);
         check_output("b2b:access_ready", 32'(req_ready), 32'd0);
         drive(1'b1, 32'h100, 32'hBAD0BAD0, 3'd2);
         @(posedge clk);
         @(negedge clk);
         check_output("b2b:resp_valid", 32'(resp_valid), 32'd1);
         check_output("b2b:rdata", resp_rdata, b2b_rd[k]);
         check_output("b2b:err", 32'(resp_err), 32'(b2b_err[k]));
         if (k < 3) drive(b2b_wr[k+1], b2b_addr[k+1], b2b_wd[k+1], b2b_f3[k+1]);
         else req_valid = 1'b0;
      end
      @(negedge clk);
      check_output("b2b:idle_valid", 32'(resp_valid), 32'd0);
      apply_stimulus(1'b0, 32'h100, 32'h0, 3'd2, "b2b_junk_ignored", 1'b0, 32'h0, 2'b00);

      // Reset during ACCESS: store dropped, no response.
      drive(1'b1, 32'h200, 32'h12345678, 3'd2);
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      reset = 1'b1;
      #1;
      check_output("rst_access:ready", 32'(req_ready), 32'd1);
      check_output("rst_access:valid", 32'(resp_valid), 32'd0);
      repeat (2) begin
         @(negedge clk);
         check_output("rst_access:no_resp", 32'(resp_valid), 32'd0);
      end
      reset = 1'b0;
      model_tohost = '0;
      check_reset_state("rst_access");
      apply_stimulus(1'b0, 32'h200, 32'h0, 3'd2, "rst_access_old", 1'b1, 32'hCAFEF00D, 2'b00);

      // Reset during RESP: response dropped, store already committed.
      model_access(1'b1, 32'h204, 32'h0BADCAFE, 3'd2, b2b_rd[0], b2b_err[0]);
      drive(1'b1, 32'h204, 32'h0BADCAFE, 3'd2);
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_output("rst_resp:valid_before", 32'(resp_valid), 32'd1);
      reset = 1'b1;
      #1;
      check_output("rst_resp:dropped", 32'(resp_valid), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      model_tohost = '0;
      apply_stimulus(1'b0, 32'h204, 32'h0, 3'd2, "rst_resp_committed", 1'b1, 32'h0BADCAFE, 2'b00);

      // Random traffic over a pre-initialised window at both ends of memory.
      for (int i = 0; i < 8; i++) begin
         apply_stimulus(1'b1, 32'(i * 4), $urandom, 3'd2, "init_lo", 1'b0, 32'h0, 2'b00);
         apply_stimulus(1'b1, 32'((DEPTH - 8 + i) * 4), $urandom, 3'd2, "init_hi", 1'b0, 32'h0, 2'b00);
      end
      for (int i = 0; i < 300; i++) begin
         r = $urandom_range(0, 99);
         if (r < 45)      word = 30'($urandom_range(0, 7));
         else if (r < 85) word = 30'(DEPTH - 8 + $urandom_range(0, 7));
         else if (r < 95) word = 30'(DEPTH + $urandom_range(0, 3));
         else             word = MMIO_ADDR[31:2];
         addr = {word, 2'(($urandom_range(0, 3)))};
         wr   = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
         else if (wr)                   f3 = 3'($urandom_range(0, 2));
         else                           f3 = ld_codes[$urandom_range(0, 4)];
         apply_stimulus(wr, addr, $urandom, f3, "rand", 1'b0, 32'h0, 2'b00);
         repeat ($urandom_range(0, 1)) @(negedge clk);
      end

      @(negedge clk);
      @(negedge clk);
      check_output("tohost_pulse_count", 32'(tohost_pulses), 32'(exp_tohost_pulses));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
